// File: rtl/rv32m_seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: XLEN+1 cycles to done, 1 cycle for /0 and overflow.
// Issuer stalls on busy; start is ignored while busy; rst/flush abort with no done pulse.
module rv32m_seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            is_rem;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsor;

  logic            sgn_op;
  logic            a_neg;
  logic            b_neg;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  // Shifted partial remainder needs one extra bit: it can reach 2*|divisor|-1.
  always_comb begin
    sgn_op  = ~op[0];
    a_neg   = sgn_op & dividend[XLEN-1];
    b_neg   = sgn_op & divisor[XLEN-1];
    a_mag   = a_neg ? -dividend : dividend;
    b_mag   = b_neg ? -divisor : divisor;
    div0    = (divisor == '0);
    ovf     = sgn_op && (dividend == MIN_NEG) && (divisor == '1);
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, dsor};
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      if (rst) begin
        result  <= '0;
        quo     <= '0;
        rem     <= '0;
        dsor    <= '0;
        is_rem  <= 1'b0;
        neg_quo <= 1'b0;
        neg_rem <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= op[1];
            busy   <= 1'b1;
            // Special cases preload final values so FIX handles every path alike.
            if (div0) begin
              quo     <= '1;
              rem     <= dividend;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              state   <= FIX;
            end else if (ovf) begin
              quo     <= MIN_NEG;
              rem     <= '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
              state   <= FIX;
            end else begin
              quo     <= a_mag;
              rem     <= '0;
              dsor    <= b_mag;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= CW'(XLEN-1);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (is_rem) begin
            result <= neg_rem ? -rem : rem;
          end else begin
            result <= neg_quo ? -quo : quo;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32m_seq_divider.sv
// Directed self-checking bench for rv32m_seq_divider (XLEN=32): results, latency, handshake, abort.
module tb_rv32m_seq_divider;
  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    logic [7:0]  lat;
  } vec_t;

  rv32m_seq_divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .flush    (flush),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from idle; returns in the done cycle (or after a 100-cycle bound).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat, bc;
    do_op(2'b01, 32'd100, 32'd7, res, lat, bc);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
    total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", lat); end
    total++; if (bc !== 33) begin bad++; $display("FAIL divu_busy_cycles: got %0d want 33", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL divu_busy_in_done: got %b want 0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL divu_done_single: got %b want 0", done); end
    do_op(2'b11, 32'd100, 32'd7, res, lat, bc);
    total++; if (res !== 32'd2) begin bad++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    tick();
  endtask

  task automatic run_table(input string name, input vec_t v[8], input int n);
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < n; i++) begin
      do_op(v[i].o, v[i].a, v[i].b, res, lat, bc);
      total++;
      if (res !== v[i].e) begin
        bad++; $display("FAIL %s[%0d] result: got %h want %h", name, i, res, v[i].e);
      end
      total++;
      if (lat !== int'(v[i].lat)) begin
        bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, v[i].lat);
      end
      tick();
    end
  endtask

  task automatic test_signed();
    vec_t v[8];
    v[0] = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 8'd33};
    v[1] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 8'd33};
    v[2] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 8'd33};
    v[3] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         8'd33};
    v[4] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         8'd33};
    for (int i = 5; i < 8; i++) v[i] = '0;
    run_table("signed", v, 5);
  endtask

  task automatic test_div_zero();
    vec_t v[8];
    v[0] = '{2'b01, 32'd5,         32'd0, 32'hFFFF_FFFF, 8'd1};
    v[1] = '{2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 8'd1};
    v[2] = '{2'b00, 32'd0,         32'd0, 32'hFFFF_FFFF, 8'd1};
    v[3] = '{2'b11, 32'd9,         32'd0, 32'd9,         8'd1};
    for (int i = 4; i < 8; i++) v[i] = '0;
    run_table("div0", v, 4);
  endtask

  task automatic test_overflow();
    vec_t v[8];
    v[0] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
    v[1] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1};
    // Unsigned 2^31 / (2^32-1) truncates to zero.
    v[2] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd33};
    v[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd33};
    for (int i = 4; i < 8; i++) v[i] = '0;
    run_table("ovf", v, 4);
  endtask

  task automatic test_back_to_back();
    int n;
    int d;
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    tick();
    dividend = 32'd999; divisor = 32'd0;
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_first_latency: got %0d want 33", n); end
    total++; if (result !== 32'd14) begin bad++; $display("FAIL b2b_first_result: got %h want %h", result, 32'd14); end
    dividend = 32'd50; divisor = 32'd5;
    tick();
    dividend = 32'd777; divisor = 32'd0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_done: got %b want 1", busy); end
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_second_latency: got %0d want 33", n); end
    total++; if (result !== 32'd10) begin bad++; $display("FAIL b2b_second_result: got %h want %h", result, 32'd10); end
    start = 1'b0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_no_extra_done: got %b want 0", done); end

    // A start pulse during RUN with different operands must be ignored.
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 2'b11; dividend = 32'd1; divisor = 32'd1;
    tick();
    start = 1'b0;
    n = 5;
    while (!done && n < 100) begin tick(); n++; end
    total++; if (n !== 33) begin bad++; $display("FAIL ignore_latency: got %0d want 33", n); end
    total++; if (result !== 32'd14) begin bad++; $display("FAIL ignore_result: got %h want %h", result, 32'd14); end
    d = 0;
    repeat (40) begin tick(); if (done) d++; end
    total++; if (d !== 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", d); end
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat, bc, d;
    do_op(2'b11, 32'd100, 32'd7, res, lat, bc);
    total++; if (res !== 32'd2) begin bad++; $display("FAIL abort_prior: got %h want %h", res, 32'd2); end
    tick();

    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    total++; if (result !== 32'd2) begin bad++; $display("FAIL flush_result_kept: got %h want %h", result, 32'd2); end
    d = 0;
    repeat (40) begin if (done) d++; tick(); end
    total++; if (d !== 0) begin bad++; $display("FAIL flush_no_done: got %0d want 0", d); end

    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result: got %h want 0", result); end

    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd0;
    tick();
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_start_done: got %b want 0", done); end

    do_op(2'b01, 32'd9, 32'd3, res, lat, bc);
    total++; if (res !== 32'd3) begin bad++; $display("FAIL fresh_divu_9_3: got %h want %h", res, 32'd3); end
    total++; if (lat !== 33) begin bad++; $display("FAIL fresh_latency: got %0d want 33", lat); end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    flush = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
